// File: rtl/block_mult_sequencer.sv
// Sequences block multiplies and accumulations for a (2*N_BLK)-square matrix product,
// driving an external block multiplier, a 4-lane adder and the A/B/C block RAMs.
module block_mult_sequencer #(
    parameter int N_BLK  = 2,
    parameter int ADDR_W = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               a_rd_en,
    output logic [ADDR_W-1:0]  a_rd_addr,
    input  logic [127:0]       a_rd_data,
    output logic               b_rd_en,
    output logic [ADDR_W-1:0]  b_rd_addr,
    input  logic [127:0]       b_rd_data,
    output logic               mul_start,
    output logic [127:0]       mul_a,
    output logic [127:0]       mul_b,
    input  logic [127:0]       mul_c,
    input  logic               mul_done,
    output logic               add_stb,
    output logic [127:0]       add_a,
    output logic [127:0]       add_b,
    input  logic [127:0]       add_z,
    input  logic               add_z_stb,
    output logic               add_z_ack,
    output logic               c_wr_en,
    output logic [ADDR_W-1:0]  c_wr_addr,
    output logic [127:0]       c_wr_data
);

    localparam int CNT_W = (N_BLK > 1) ? $clog2(N_BLK) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_BLK - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_LOAD,
        S_MUL,
        S_ACC,
        S_WR,
        S_DONE
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] i_reg, j_reg, k_reg;
    logic [127:0]     mul_a_reg, mul_b_reg, prod_reg, acc_reg;
    logic             mul_start_reg, add_z_ack_reg;
    logic             i_last, j_last, k_last;

    assign i_last = (i_reg == CNT_LAST);
    assign j_last = (j_reg == CNT_LAST);
    assign k_last = (k_reg == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (start) state_next = S_RD;
            S_RD:    state_next = S_LOAD;
            S_LOAD:  state_next = S_MUL;
            S_MUL: begin
                // The first partial product seeds the accumulator without an add.
                if (mul_done) begin
                    if (k_reg != '0)  state_next = S_ACC;
                    else if (k_last)  state_next = S_WR;
                    else              state_next = S_RD;
                end
            end
            S_ACC:   if (add_z_stb) state_next = k_last ? S_WR : S_RD;
            S_WR:    state_next = (i_last && j_last) ? S_DONE : S_RD;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_reg         <= '0;
            j_reg         <= '0;
            k_reg         <= '0;
            mul_a_reg     <= '0;
            mul_b_reg     <= '0;
            prod_reg      <= '0;
            acc_reg       <= '0;
            mul_start_reg <= 1'b0;
            add_z_ack_reg <= 1'b0;
        end else begin
            mul_start_reg <= (state_reg == S_LOAD);
            add_z_ack_reg <= (state_reg == S_ACC) && add_z_stb;
            case (state_reg)
                S_LOAD: begin
                    mul_a_reg <= a_rd_data;
                    mul_b_reg <= b_rd_data;
                end
                S_MUL: begin
                    if (mul_done) begin
                        prod_reg <= mul_c;
                        if (k_reg == '0) begin
                            acc_reg <= mul_c;
                            if (!k_last) k_reg <= k_reg + CNT_W'(1);
                        end
                    end
                end
                S_ACC: begin
                    if (add_z_stb) begin
                        acc_reg <= add_z;
                        if (!k_last) k_reg <= k_reg + CNT_W'(1);
                    end
                end
                S_WR: begin
                    k_reg <= '0;
                    if (j_last) begin
                        j_reg <= '0;
                        i_reg <= i_last ? '0 : i_reg + CNT_W'(1);
                    end else begin
                        j_reg <= j_reg + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    i_reg <= '0;
                    j_reg <= '0;
                    k_reg <= '0;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state_reg == S_RD) || (state_reg == S_LOAD) || (state_reg == S_MUL) ||
                       (state_reg == S_ACC) || (state_reg == S_WR);
    assign done      = (state_reg == S_DONE);
    assign a_rd_en   = (state_reg == S_RD);
    assign b_rd_en   = (state_reg == S_RD);
    assign a_rd_addr = ADDR_W'(i_reg) * ADDR_W'(N_BLK) + ADDR_W'(k_reg);
    assign b_rd_addr = ADDR_W'(k_reg) * ADDR_W'(N_BLK) + ADDR_W'(j_reg);
    assign c_wr_addr = ADDR_W'(i_reg) * ADDR_W'(N_BLK) + ADDR_W'(j_reg);
    assign mul_start = mul_start_reg;
    assign mul_a     = mul_a_reg;
    assign mul_b     = mul_b_reg;
    assign add_stb   = (state_reg == S_ACC);
    assign add_a     = acc_reg;
    assign add_b     = prod_reg;
    assign add_z_ack = add_z_ack_reg;
    assign c_wr_en   = (state_reg == S_WR);
    assign c_wr_data = acc_reg;

endmodule

// File: tb/tb_block_mult_sequencer.sv
// Bench for block_mult_sequencer: RAM, multiplier and adder models plus a full-matrix
// reference product (lanes treated as 32-bit integers since the block passes data through).
module tb_block_mult_sequencer;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    always #5 clk = ~clk;

    // N_BLK=2 instance
    logic         start = 1'b0;
    logic         busy, done, a_rd_en, b_rd_en, mul_start, add_stb, add_z_ack, c_wr_en;
    logic         mul_done = 1'b0;
    logic         add_z_stb = 1'b0;
    logic [1:0]   a_rd_addr, b_rd_addr, c_wr_addr;
    logic [127:0] a_rd_data = '0;
    logic [127:0] b_rd_data = '0;
    logic [127:0] mul_c = '0;
    logic [127:0] add_z = '0;
    logic [127:0] mul_a, mul_b, add_a, add_b, c_wr_data;

    // N_BLK=1 instance
    logic         start_1 = 1'b0;
    logic         busy_1, done_1, a_rd_en_1, b_rd_en_1, mul_start_1, add_stb_1, add_z_ack_1, c_wr_en_1;
    logic         mul_done_1 = 1'b0;
    logic         add_z_stb_1 = 1'b0;
    logic [0:0]   a_rd_addr_1, b_rd_addr_1, c_wr_addr_1;
    logic [127:0] a_rd_data_1 = '0;
    logic [127:0] b_rd_data_1 = '0;
    logic [127:0] mul_c_1 = '0;
    logic [127:0] add_z_1 = '0;
    logic [127:0] mul_a_1, mul_b_1, add_a_1, add_b_1, c_wr_data_1;

    block_mult_sequencer #(.N_BLK(2), .ADDR_W(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr), .a_rd_data(a_rd_data),
        .b_rd_en(b_rd_en), .b_rd_addr(b_rd_addr), .b_rd_data(b_rd_data),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c), .mul_done(mul_done),
        .add_stb(add_stb), .add_a(add_a), .add_b(add_b), .add_z(add_z), .add_z_stb(add_z_stb),
        .add_z_ack(add_z_ack), .c_wr_en(c_wr_en), .c_wr_addr(c_wr_addr), .c_wr_data(c_wr_data)
    );

    block_mult_sequencer #(.N_BLK(1), .ADDR_W(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_1), .busy(busy_1), .done(done_1),
        .a_rd_en(a_rd_en_1), .a_rd_addr(a_rd_addr_1), .a_rd_data(a_rd_data_1),
        .b_rd_en(b_rd_en_1), .b_rd_addr(b_rd_addr_1), .b_rd_data(b_rd_data_1),
        .mul_start(mul_start_1), .mul_a(mul_a_1), .mul_b(mul_b_1), .mul_c(mul_c_1), .mul_done(mul_done_1),
        .add_stb(add_stb_1), .add_a(add_a_1), .add_b(add_b_1), .add_z(add_z_1), .add_z_stb(add_z_stb_1),
        .add_z_ack(add_z_ack_1), .c_wr_en(c_wr_en_1), .c_wr_addr(c_wr_addr_1), .c_wr_data(c_wr_data_1)
    );

    logic [127:0] a_mem [4];
    logic [127:0] b_mem [4];
    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] elem(input logic [127:0] blk, input int r, input int c);
        return blk[127-32*(r*2+c) -: 32];
    endfunction

    // Multiplier model: 2x2 block product, lanes as 32-bit integers.
    function automatic logic [127:0] blockmul(input logic [127:0] a, input logic [127:0] b);
        logic [127:0] r;
        for (int ri = 0; ri < 2; ri++)
            for (int ci = 0; ci < 2; ci++)
                r[127-32*(ri*2+ci) -: 32] = elem(a, ri, 0) * elem(b, 0, ci) + elem(a, ri, 1) * elem(b, 1, ci);
        return r;
    endfunction

    function automatic logic [127:0] lanesum(input logic [127:0] a, input logic [127:0] b);
        logic [127:0] r;
        for (int l = 0; l < 4; l++) r[127-32*l -: 32] = a[127-32*l -: 32] + b[127-32*l -: 32];
        return r;
    endfunction

    // Reference: element-wise full-matrix product C[r][c] = sum_m A[r][m]*B[m][c].
    function automatic logic [127:0] ref_c(input int n, input int bi, input int bj);
        logic [127:0] res;
        logic [31:0]  s;
        int ar, bc;
        res = '0;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++) begin
                s  = '0;
                ar = 2*bi + r;
                bc = 2*bj + c;
                for (int m = 0; m < 2*n; m++)
                    s += elem(a_mem[(ar/2)*n + m/2], ar%2, m%2) * elem(b_mem[(m/2)*n + bc/2], m%2, bc%2);
                res[127-32*(r*2+c) -: 32] = s;
            end
        return res;
    endfunction

    function automatic logic [127:0] rand_blk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (a_rd_en)   a_rd_data   <= a_mem[a_rd_addr];
        if (b_rd_en)   b_rd_data   <= b_mem[b_rd_addr];
        if (a_rd_en_1) a_rd_data_1 <= a_mem[int'(a_rd_addr_1)];
        if (b_rd_en_1) b_rd_data_1 <= b_mem[int'(b_rd_addr_1)];
    end

    // N_BLK=2 environment: models and monitors, all on the falling edge
    int mul_lat = 1, add_lat = 0;
    bit spurious = 0;
    bit mul_busy = 0, add_pend = 0;
    int mul_cnt, add_cnt;
    logic [127:0] mul_a_snap, mul_b_snap, add_a_snap, add_b_snap;
    int n_mul, n_ack, n_wr, n_done, n_stb_rise, stab_err, overlap_err, pulse_err;
    int last_wr_cyc, done_cyc;
    bit prev_ack, prev_mul_start, prev_stb;
    logic [1:0]   a_q[$], b_q[$], wa_q[$];
    logic [127:0] wd_q[$];

    always @(negedge clk) begin
        mul_done  = 1'b0;
        add_z_stb = 1'b0;
        if (!rst_n) begin
            mul_busy = 0; add_pend = 0;
            prev_ack = 0; prev_mul_start = 0; prev_stb = 0;
        end else begin
            if (mul_busy) begin
                if (mul_a !== mul_a_snap || mul_b !== mul_b_snap) stab_err++;
                if (mul_cnt == 0) begin
                    mul_done = 1'b1;
                    mul_c    = blockmul(mul_a, mul_b);
                    mul_busy = 0;
                end else mul_cnt--;
            end else if (mul_start) begin
                mul_busy = 1; mul_cnt = mul_lat; mul_a_snap = mul_a; mul_b_snap = mul_b;
            end
            if (add_pend) begin
                if (add_stb !== 1'b1 || add_a !== add_a_snap || add_b !== add_b_snap) stab_err++;
                if (add_cnt == 0) begin
                    add_z_stb = 1'b1;
                    add_z     = lanesum(add_a, add_b);
                    add_pend  = 0;
                end else add_cnt--;
            end else if (add_stb) begin
                add_pend = 1; add_cnt = add_lat; add_a_snap = add_a; add_b_snap = add_b;
            end
            if (spurious && a_rd_en) begin
                mul_done = 1'b1; mul_c = rand_blk();
                add_z_stb = 1'b1; add_z = rand_blk();
            end
            if (mul_start) n_mul++;
            if (mul_start && (add_stb || add_pend)) overlap_err++;
            if (mul_start && prev_mul_start) pulse_err++;
            if (add_z_ack) n_ack++;
            if (add_z_ack && prev_ack) pulse_err++;
            if (add_stb && !prev_stb) n_stb_rise++;
            if (a_rd_en) begin a_q.push_back(a_rd_addr); b_q.push_back(b_rd_addr); end
            if (c_wr_en) begin
                wa_q.push_back(c_wr_addr); wd_q.push_back(c_wr_data);
                n_wr++; last_wr_cyc = cyc;
                $display("C write addr=%0d data=%h", c_wr_addr, c_wr_data);
            end
            if (done) begin n_done++; done_cyc = cyc; end
            prev_ack = add_z_ack; prev_mul_start = mul_start; prev_stb = add_stb;
        end
    end

    // N_BLK=1 environment
    bit m1_busy = 0;
    int n1_mul, n1_add, n1_wr, n1_done;
    logic [127:0] m1_last, w1_data;
    logic [0:0]   w1_addr;

    always @(negedge clk) begin
        mul_done_1 = 1'b0;
        if (!rst_n) m1_busy = 0;
        else begin
            if (m1_busy) begin
                mul_done_1 = 1'b1; mul_c_1 = blockmul(mul_a_1, mul_b_1);
                m1_last = mul_c_1; m1_busy = 0;
            end else if (mul_start_1) m1_busy = 1;
            if (mul_start_1) n1_mul++;
            if (add_stb_1)   n1_add++;
            if (c_wr_en_1) begin
                n1_wr++; w1_addr = c_wr_addr_1; w1_data = c_wr_data_1;
                $display("C1 write addr=%0d data=%h", c_wr_addr_1, c_wr_data_1);
            end
            if (done_1) n1_done++;
        end
    end

    task automatic clear_mon();
        n_mul = 0; n_ack = 0; n_wr = 0; n_done = 0; n_stb_rise = 0;
        stab_err = 0; overlap_err = 0; pulse_err = 0;
        last_wr_cyc = 0; done_cyc = 0;
        a_q.delete(); b_q.delete(); wa_q.delete(); wd_q.delete();
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ctl"}, {busy, done, a_rd_en, b_rd_en, mul_start, add_stb, add_z_ack, c_wr_en,
                              a_rd_addr, b_rd_addr, c_wr_addr}, '0);
        check({tag, "_mul_a"}, mul_a, '0);
        check({tag, "_mul_b"}, mul_b, '0);
        check({tag, "_add_a"}, add_a, '0);
        check({tag, "_add_b"}, add_b, '0);
        check({tag, "_c_data"}, c_wr_data, '0);
    endtask

    // Called 1 time unit after a falling edge.
    task automatic run2(input bit poke);
        clear_mon();
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk); #1;
            start = poke && (c == 6 || c == 20);
            if (n_done > 0) break;
        end
        start = 1'b0;
        repeat (6) @(negedge clk);
        #1;
    endtask

    task automatic verify2(input string tag);
        int idx;
        check({tag, "_busy_after"}, busy, 1'b0);
        check({tag, "_n_done"}, n_done, 1);
        check({tag, "_n_mul"}, n_mul, 8);
        check({tag, "_n_ack"}, n_ack, 4);
        check({tag, "_n_wr"}, n_wr, 4);
        check({tag, "_n_rd"}, a_q.size(), 8);
        check({tag, "_done_gap"}, done_cyc - last_wr_cyc, 1);
        check({tag, "_stable"}, stab_err, 0);
        check({tag, "_mul_vs_add"}, overlap_err, 0);
        check({tag, "_pulses"}, pulse_err, 0);
        idx = 0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                if (idx < wa_q.size()) begin
                    check({tag, "_wr_addr"}, wa_q[idx], i*2 + j);
                    check({tag, "_wr_data"}, wd_q[idx], ref_c(2, i, j));
                end
                idx++;
            end
        idx = 0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                for (int k = 0; k < 2; k++) begin
                    if (idx < a_q.size()) begin
                        check({tag, "_a_addr"}, a_q[idx], i*2 + k);
                        check({tag, "_b_addr"}, b_q[idx], k*2 + j);
                    end
                    idx++;
                end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check_idle("reset");
        rst_n = 1'b1;
        @(negedge clk); #1;
        check_idle("post_reset");

        // All-ones matrices
        for (int x = 0; x < 4; x++) begin a_mem[x] = {4{32'd1}}; b_mem[x] = {4{32'd1}}; end
        run2(0);
        verify2("ones");
        if (wd_q.size() > 0) check("ones_word", wd_q[0][127:96], 32'd4);

        // Identity times random: C must equal B exactly
        a_mem[0] = {32'd1, 32'd0, 32'd0, 32'd1}; a_mem[1] = '0;
        a_mem[2] = '0;                           a_mem[3] = {32'd1, 32'd0, 32'd0, 32'd1};
        for (int x = 0; x < 4; x++) b_mem[x] = rand_blk();
        run2(0);
        verify2("ident");
        for (int x = 0; x < 4; x++)
            if (x < wd_q.size()) check("ident_c_eq_b", wd_q[x], b_mem[x]);

        // Slow adder: operands must hold for the whole wait
        for (int x = 0; x < 4; x++) begin a_mem[x] = rand_blk(); b_mem[x] = rand_blk(); end
        add_lat = 10;
        run2(0);
        verify2("slow_add");

        // Restart attempts and stray handshakes while busy
        add_lat  = 1;
        spurious = 1;
        run2(1);
        verify2("spurious");
        spurious = 0;

        // Randomised latencies and data
        for (int t = 0; t < 4; t++) begin
            mul_lat = $urandom_range(0, 4);
            add_lat = $urandom_range(0, 3);
            for (int x = 0; x < 4; x++) begin a_mem[x] = rand_blk(); b_mem[x] = rand_blk(); end
            run2(0);
            verify2("rand");
        end

        // Asynchronous reset in the second accumulate, then a clean rerun
        mul_lat = 1; add_lat = 4;
        clear_mon();
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 500; c++) begin
            if (n_stb_rise >= 2) break;
            @(negedge clk); #1;
        end
        check("mid_run_second_acc", n_stb_rise, 2);
        #1 rst_n = 1'b0;
        #1;
        check_idle("async_rst");
        @(negedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk); #1;
        run2(0);
        verify2("after_rst");

        // N_BLK = 1
        a_mem[0] = {4{32'h3f800000}};
        b_mem[0] = {4{32'h40000000}};
        for (int t = 0; t < 2; t++) begin
            n1_mul = 0; n1_add = 0; n1_wr = 0; n1_done = 0; w1_addr = 1'b1; w1_data = 'x;
            start_1 = 1'b1;
            @(negedge clk); #1;
            start_1 = 1'b0;
            for (int c = 0; c < 200; c++) begin
                @(negedge clk); #1;
                if (n1_done > 0) break;
            end
            repeat (3) @(negedge clk);
            #1;
            check("n1_done", n1_done, 1);
            check("n1_mul", n1_mul, 1);
            check("n1_add_stb", n1_add, 0);
            check("n1_wr", n1_wr, 1);
            check("n1_addr", w1_addr, 0);
            check("n1_data_ref", w1_data, ref_c(1, 0, 0));
            check("n1_data_mulc", w1_data, m1_last);
            a_mem[0] = rand_blk();
            b_mem[0] = rand_blk();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
